// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host command path.
// Imported by the command sequencer and its frame shifter.
package ps2_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_TX,
      S_WAIT_RESP
   } ps2_state_e;

   localparam logic [1:0] ERR_TIMEOUT = 2'd0;
   localparam logic [1:0] ERR_NO_ACK  = 2'd1;
   localparam logic [1:0] ERR_RESEND  = 2'd2;
   localparam logic [1:0] ERR_UNEXP   = 2'd3;

   localparam logic [7:0] PS2_ACK      = 8'hFA;
   localparam logic [7:0] PS2_RESEND   = 8'hFE;
   localparam logic [7:0] PS2_CMD_LEDS = 8'hED;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_tx_frame.sv
// Host-to-device frame shifter: data, parity, stop, then line-ACK sample.
// Advances only on synchronised device clock falls after a start pulse.
module ps2_tx_frame
   import ps2_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_start,
   input  logic       i_fall,
   input  logic [7:0] i_byte,
   input  logic       i_data,
   output logic       o_data_low,
   output logic       o_frame_done,
   output logic       o_line_ack
);

   logic [7:0] r_shift;
   logic       r_parity;
   logic [3:0] r_bitcnt;
   logic       r_active;
   logic       r_data_low;
   logic       r_done;
   logic       r_ack;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_bitcnt   <= '0;
         r_active   <= 1'b0;
         r_data_low <= 1'b0;
         r_done     <= 1'b0;
         r_ack      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_shift    <= i_byte;
            r_parity   <= odd_parity(i_byte);
            r_bitcnt   <= '0;
            r_active   <= 1'b1;
            r_data_low <= 1'b1;
            r_ack      <= 1'b0;
         end else if (i_fall && r_active) begin
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt < 4'd8) begin
               r_data_low <= ~r_shift[0];
               r_shift    <= {1'b0, r_shift[7:1]};
            end else if (r_bitcnt == 4'd8) begin
               r_data_low <= ~r_parity;
            end else if (r_bitcnt == 4'd9) begin
               r_data_low <= 1'b0;
            end else begin
               // Fall 11: device should be holding data low as line ACK
               r_done     <= 1'b1;
               r_ack      <= ~i_data;
               r_active   <= 1'b0;
               r_data_low <= 1'b0;
            end
         end
      end
   end

   assign o_data_low   = r_data_low;
   assign o_frame_done = r_done;
   assign o_line_ack   = r_ack;

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 keyboard host command sequencer: inhibit, RTS, frame out,
// line ACK and 0xFA/0xFE response handling with resend and watchdog.
module ps2_host_ctrl
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int MAX_RETRY      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2k_clk,
   input  logic       ps2k_data,
   output logic       ps2_clk_low,
   output logic       ps2_data_low,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_two,
   input  logic [7:0] cmd_byte0,
   input  logic [7:0] cmd_byte1,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic       rx_suppress,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code
);

   localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                         INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int TW = $clog2(TMAX + 1);
   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   ps2_state_e    r_state;
   ps2_state_e    w_nxt;
   logic [2:0]    r_clk_s;
   logic [1:0]    r_dat_s;
   logic [TW-1:0] r_tmr;
   logic [RW-1:0] r_retry;
   logic [7:0]    r_b0;
   logic [7:0]    r_b1;
   logic          r_two;
   logic          r_sel;
   logic          r_done;
   logic          r_err;
   logic [1:0]    r_code;

   logic          w_fall;
   logic          w_tout;
   logic          w_accept;
   logic          w_next_byte;
   logic          w_resend;
   logic          w_done;
   logic          w_err;
   logic [1:0]    w_code;
   logic [7:0]    w_cur;
   logic          w_tx_low;
   logic          w_frame_done;
   logic          w_line_ack;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_clk_s <= '0;
         r_dat_s <= '0;
      end else begin
         r_clk_s <= {r_clk_s[1:0], ps2k_clk};
         r_dat_s <= {r_dat_s[0], ps2k_data};
      end
   end

   assign w_fall   = ~r_clk_s[1] & r_clk_s[2];
   assign w_tout   = (r_tmr == TO_LAST) & ~w_fall;
   assign w_accept = cmd_valid & (r_state == S_IDLE);
   assign w_cur    = r_sel ? r_b1 : r_b0;

   ps2_tx_frame u_frame (
      .clk          (clk),
      .rst          (rst),
      .i_start      (r_state == S_RTS),
      .i_fall       (w_fall),
      .i_byte       (w_cur),
      .i_data       (r_dat_s[1]),
      .o_data_low   (w_tx_low),
      .o_frame_done (w_frame_done),
      .o_line_ack   (w_line_ack)
   );

   always_comb begin
      w_nxt       = r_state;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_code      = r_code;
      w_next_byte = 1'b0;
      w_resend    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (cmd_valid) w_nxt = S_INHIBIT;
         end
         S_INHIBIT: begin
            if (r_tmr == INH_LAST) w_nxt = S_RTS;
         end
         S_RTS: begin
            if (w_tout) begin
               w_nxt  = S_IDLE;
               w_err  = 1'b1;
               w_code = ERR_TIMEOUT;
            end else begin
               w_nxt = S_TX;
            end
         end
         S_TX: begin
            if (w_frame_done) begin
               if (w_line_ack) begin
                  w_nxt = S_WAIT_RESP;
               end else begin
                  w_nxt  = S_IDLE;
                  w_err  = 1'b1;
                  w_code = ERR_NO_ACK;
               end
            end else if (w_tout) begin
               w_nxt  = S_IDLE;
               w_err  = 1'b1;
               w_code = ERR_TIMEOUT;
            end
         end
         S_WAIT_RESP: begin
            if (rx_valid) begin
               if (rx_byte == PS2_ACK) begin
                  if (r_two && !r_sel) begin
                     w_nxt       = S_INHIBIT;
                     w_next_byte = 1'b1;
                  end else begin
                     w_nxt  = S_IDLE;
                     w_done = 1'b1;
                  end
               end else if (rx_byte == PS2_RESEND) begin
                  if (r_retry < RETRY_MAX) begin
                     w_nxt    = S_INHIBIT;
                     w_resend = 1'b1;
                  end else begin
                     w_nxt  = S_IDLE;
                     w_err  = 1'b1;
                     w_code = ERR_RESEND;
                  end
               end else begin
                  w_nxt  = S_IDLE;
                  w_err  = 1'b1;
                  w_code = ERR_UNEXP;
               end
            end else if (w_tout) begin
               w_nxt  = S_IDLE;
               w_err  = 1'b1;
               w_code = ERR_TIMEOUT;
            end
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_code  <= ERR_TIMEOUT;
      end else begin
         r_state <= w_nxt;
         r_done  <= w_done;
         r_err   <= w_err;
         if (w_err) r_code <= w_code;
      end
   end

   // RTS and TX form one watchdog phase; own clock pull is ignored
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tmr <= '0;
      end else if (r_state != w_nxt && w_nxt != S_TX) begin
         r_tmr <= '0;
      end else if (w_fall && r_state != S_INHIBIT) begin
         r_tmr <= '0;
      end else if (r_state != S_IDLE) begin
         r_tmr <= r_tmr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_b0    <= '0;
         r_b1    <= '0;
         r_two   <= 1'b0;
         r_sel   <= 1'b0;
         r_retry <= '0;
      end else if (w_accept) begin
         r_b0    <= cmd_byte0;
         r_b1    <= cmd_byte1;
         r_two   <= cmd_two;
         r_sel   <= 1'b0;
         r_retry <= '0;
      end else if (w_next_byte) begin
         r_sel   <= 1'b1;
         r_retry <= '0;
      end else if (w_resend) begin
         r_retry <= r_retry + 1'b1;
      end
   end

   assign ps2_clk_low  = (r_state == S_INHIBIT);
   assign ps2_data_low = (r_state == S_RTS) |
                         ((r_state == S_TX) & w_tx_low);
   assign cmd_ready    = (r_state == S_IDLE);
   assign busy         = (r_state != S_IDLE);
   assign rx_suppress  = (r_state == S_WAIT_RESP);
   assign done         = r_done;
   assign err          = r_err;
   assign err_code     = r_code;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl with a simple PS/2 device model.
// Table of command scenarios plus timeout and mid-frame reset sequences.
module tb_ps2_host_ctrl;

   localparam int INH = 50;
   localparam int TO  = 400;
   localparam int H   = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2k_clk;
   logic       ps2k_data;
   logic       ps2_clk_low;
   logic       ps2_data_low;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_two;
   logic [7:0] cmd_byte0;
   logic [7:0] cmd_byte1;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       rx_suppress;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] err_code;

   logic dclk;
   logic ddata_low;

   assign ps2k_clk  = dclk & ~ps2_clk_low;
   assign ps2k_data = ~ps2_data_low & ~ddata_low;

   ps2_host_ctrl #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO),
      .MAX_RETRY      (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ps2k_clk     (ps2k_clk),
      .ps2k_data    (ps2k_data),
      .ps2_clk_low  (ps2_clk_low),
      .ps2_data_low (ps2_data_low),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_two      (cmd_two),
      .cmd_byte0    (cmd_byte0),
      .cmd_byte1    (cmd_byte1),
      .rx_valid     (rx_valid),
      .rx_byte      (rx_byte),
      .rx_suppress  (rx_suppress),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .err_code     (err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            two;
      logic [7:0]      b0;
      logic [7:0]      b1;
      int              nfr;
      logic [3:0][7:0] fb;
      logic [3:0][7:0] rsp;
      logic            lack;
      logic            edone;
      logic [1:0]      ecode;
   } vec_t;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         done_cnt = 0;
   int         err_cnt  = 0;
   int         bad_evt  = 0;
   int         inh_run  = 0;
   int         inh_cnt  = 0;
   int         last_inh = 0;
   logic [1:0] exp_code = 2'd0;
   vec_t       vecs [9];

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if ((done || err) && (busy || !cmd_ready || (done && err))) bad_evt++;
      if (ps2_clk_low) begin
         inh_run++;
      end else if (inh_run != 0) begin
         last_inh = inh_run;
         inh_cnt++;
         inh_run = 0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic two, input logic [7:0] b0,
                               input logic [7:0] b1, input int nfr,
                               input logic [7:0] f0, input logic [7:0] f1,
                               input logic [7:0] f2, input logic [7:0] r0,
                               input logic [7:0] r1, input logic [7:0] r2,
                               input logic lack, input logic edone,
                               input logic [1:0] code);
      vec_t v;
      v.two   = two;
      v.b0    = b0;
      v.b1    = b1;
      v.nfr   = nfr;
      v.fb    = {8'h00, f2, f1, f0};
      v.rsp   = {8'h00, r2, r1, r0};
      v.lack  = lack;
      v.edone = edone;
      v.ecode = code;
      return v;
   endfunction

   task automatic dev_frame(input logic lack, input int abort_at,
                            output logic [9:0] bits, output logic seen);
      int n;
      seen = 1'b0;
      bits = '0;
      n = 0;
      while (!seen && n < 2000) begin
         @(negedge clk);
         n++;
         if (ps2_data_low && !ps2_clk_low) seen = 1'b1;
      end
      if (!seen) return;
      repeat (H) @(negedge clk);
      for (int i = 1; i <= 11; i++) begin
         dclk = 1'b0;
         repeat (H) @(negedge clk);
         if (i == abort_at) return;
         if (i <= 10) bits[i-1] = ps2k_data;
         if (i == 5) chk("rx_suppress_tx", 32'(rx_suppress), 0);
         dclk = 1'b1;
         if (i == 10) ddata_low = lack;
         if (i == 11) ddata_low = 1'b0;
         repeat (H) @(negedge clk);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int         d0;
      int         e0;
      int         i0;
      int         n;
      logic [9:0] bits;
      logic       seen;
      d0 = done_cnt;
      e0 = err_cnt;
      i0 = inh_cnt;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_two   = v.two;
      cmd_byte0 = v.b0;
      cmd_byte1 = v.b1;
      @(negedge clk);
      chk("cmd_ready_drop", 32'(cmd_ready), 0);
      chk("busy_after_accept", 32'(busy), 1);
      repeat (2) @(negedge clk);
      cmd_valid = 1'b0;
      for (int f = 0; f < v.nfr; f++) begin
         dev_frame(v.lack, 0, bits, seen);
         chk("rts_seen", 32'(seen), 1);
         if (!seen) break;
         chk("frame_byte", 32'(bits[7:0]), 32'(v.fb[f]));
         chk("parity", 32'(bits[8]), 32'(~^v.fb[f]));
         chk("stop_released", 32'(bits[9]), 1);
         chk("inhibit_len", last_inh, INH);
         if (v.lack) begin
            n = 0;
            while (!rx_suppress && n < 100) begin
               @(negedge clk);
               n++;
            end
            chk("rx_suppress_resp", 32'(rx_suppress), 1);
            rx_valid = 1'b1;
            rx_byte  = v.rsp[f];
            @(negedge clk);
            rx_valid = 1'b0;
         end
      end
      n = 0;
      while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!v.edone) exp_code = v.ecode;
      chk("done_count", done_cnt - d0, 32'(v.edone));
      chk("err_count", err_cnt - e0, 32'(!v.edone));
      chk("err_code", 32'(err_code), 32'(exp_code));
      chk("inhibit_phases", inh_cnt - i0, v.nfr);
      chk("lines_released", 32'({ps2_clk_low, ps2_data_low}), 0);
      chk("cmd_ready_idle", 32'(cmd_ready), 1);
      chk("rx_suppress_idle", 32'(rx_suppress), 0);
      repeat (5) @(negedge clk);
   endtask

   initial begin
      logic [9:0] bits;
      logic       seen;
      int         n;
      int         t0;
      int         t1;

      vecs[0] = mk(0, 8'hF4, 8'h00, 1, 8'hF4, 8'h00, 8'h00,
                   8'hFA, 8'h00, 8'h00, 1, 1, 2'd0);
      vecs[1] = mk(1, 8'hED, 8'h07, 2, 8'hED, 8'h07, 8'h00,
                   8'hFA, 8'hFA, 8'h00, 1, 1, 2'd0);
      vecs[2] = mk(0, 8'hFF, 8'h00, 3, 8'hFF, 8'hFF, 8'hFF,
                   8'hFE, 8'hFE, 8'hFA, 1, 1, 2'd0);
      vecs[3] = mk(0, 8'hFF, 8'h00, 3, 8'hFF, 8'hFF, 8'hFF,
                   8'hFE, 8'hFE, 8'hFE, 1, 0, 2'd2);
      vecs[4] = mk(0, 8'hF4, 8'h00, 1, 8'hF4, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 0, 0, 2'd1);
      vecs[5] = mk(0, 8'hF4, 8'h00, 1, 8'hF4, 8'h00, 8'h00,
                   8'h41, 8'h00, 8'h00, 1, 0, 2'd3);
      vecs[6] = mk(1, 8'hED, 8'h07, 3, 8'hED, 8'h07, 8'h07,
                   8'hFA, 8'hFE, 8'hFA, 1, 1, 2'd0);
      vecs[7] = mk(1, 8'hED, 8'h07, 3, 8'hED, 8'hED, 8'h07,
                   8'hFE, 8'hFA, 8'hFA, 1, 1, 2'd0);
      vecs[8] = mk(1, 8'hED, 8'h07, 2, 8'hED, 8'h07, 8'h00,
                   8'hFA, 8'h41, 8'h00, 1, 0, 2'd3);

      rst       = 1'b0;
      dclk      = 1'b1;
      ddata_low = 1'b0;
      cmd_valid = 1'b0;
      cmd_two   = 1'b0;
      cmd_byte0 = '0;
      cmd_byte1 = '0;
      rx_valid  = 1'b0;
      rx_byte   = '0;

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done_err", 32'({done, err}), 0);
      chk("rst_err_code", 32'(err_code), 0);
      chk("rst_lines", 32'({ps2_clk_low, ps2_data_low}), 0);
      chk("rst_rx_suppress", 32'(rx_suppress), 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Device never clocks after RTS
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_two   = 1'b0;
      cmd_byte0 = 8'hF4;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!(ps2_data_low && !ps2_clk_low) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("to_rts_seen", 32'(ps2_data_low && !ps2_clk_low), 1);
      t0 = cyc;
      n = 0;
      while (!err && n < 2 * TO) begin
         @(negedge clk);
         n++;
      end
      t1 = cyc;
      exp_code = 2'd0;
      chk("to_err", 32'(err), 1);
      chk("to_cycles", t1 - t0, TO);
      chk("to_code", 32'(err_code), 32'(exp_code));
      chk("to_lines", 32'({ps2_clk_low, ps2_data_low}), 0);
      @(negedge clk);
      chk("to_cmd_ready", 32'(cmd_ready), 1);
      repeat (3) @(negedge clk);

      // Asynchronous reset in the middle of a frame
      cmd_valid = 1'b1;
      cmd_byte0 = 8'hF4;
      @(negedge clk);
      cmd_valid = 1'b0;
      dev_frame(1'b1, 5, bits, seen);
      chk("mid_rts_seen", 32'(seen), 1);
      chk("mid_busy", 32'(busy), 1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_lines", 32'({ps2_clk_low, ps2_data_low}), 0);
      chk("mid_rst_ready", 32'(cmd_ready), 1);
      @(negedge clk);
      rst  = 1'b1;
      dclk = 1'b1;
      exp_code = 2'd0;
      chk("mid_rst_code", 32'(err_code), 0);
      repeat (5) @(negedge clk);
      run_vec(vecs[2]);
      run_vec(vecs[0]);

      chk("evt_in_idle", bad_evt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_host_ctrl.md
Name: ps2_host_ctrl

Overview:
Host-side command sequencer for the PS/2 keyboard port. Sends 1- or 2-byte commands to the keyboard, e.g. 0xED + LED mask, 0xF4 enable, 0xFF reset. It does this by inhibiting the clock, issuing request-to-send and shifting frames out on device clock edges. It then checks the line ACK and the 0xFA response byte. The response byte arrives from the existing receive scanner. The block arbitrates the shared open-drain lines and tells the keystroke consumer to discard response bytes.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the clock line is held low before RTS (100 us at 50 MHz)
TIMEOUT_CYCLES, 1000000, per-phase watchdog in clk cycles (20 ms at 50 MHz)
MAX_RETRY, 2, resend attempts per byte after the first transmission

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ps2k_clk  in  1  raw PS/2 clock pin level
ps2k_data  in  1  raw PS/2 data pin level
ps2_clk_low  out  1  1 = pull clock line low (open-drain enable)
ps2_data_low  out  1  1 = pull data line low (open-drain enable)
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE only
cmd_two  in  1  1 = send cmd_byte1 after cmd_byte0
cmd_byte0  in  8  first command byte
cmd_byte1  in  8  second command byte (argument)
rx_valid  in  1  1-cycle pulse, byte received by scanner
rx_byte  in  8  received byte
rx_suppress  out  1  high in WAIT_RESP; consumer drops rx bytes while high
busy  out  1  high whenever not IDLE
done  out  1  1-cycle pulse, command fully acknowledged
err  out  1  1-cycle pulse, command aborted
err_code  out  2  0 timeout, 1 no line ACK, 2 resend exhausted, 3 unexpected response; held until next err

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0 except cmd_ready=1. Both lines released. Counters, retry count and synchronisers cleared. Reset mid-frame releases the lines on the asynchronous reset edge.
- Clock sync: 3-flop chain on ps2k_clk. fall = ~s1 & s2, i.e. edge seen 2-3 cycles after the pin changes. ps2k_data is 2-flop synchronised.
- Handshake: a command is accepted when cmd_valid & cmd_ready. The bytes and cmd_two are latched on accept. cmd_ready drops the next cycle.
- IDLE -> INHIBIT on accept. Load the shift register with the current byte. Compute parity = ~^byte (odd). Clear retry count.
- INHIBIT: ps2_clk_low=1 for exactly INHIBIT_CYCLES cycles, then go to RTS.
- RTS: ps2_data_low=1 (start bit) and ps2_clk_low=0 on the same cycle. bitcnt=0. Watchdog starts.
- TX: on each fall, bitcnt increments.
  - fall 1..8: drive data bit 0..7, LSB first (ps2_data_low = ~bit).
  - fall 9: drive parity.
  - fall 10: release data (stop bit).
  - fall 11: sample data. Sample 0 -> WAIT_RESP. Sample 1 -> err code 1.
- WAIT_RESP: watchdog restarted.
  - rx_valid with 0xFA -> next byte if cmd_two and byte0 was just sent (reload, go to INHIBIT); otherwise done.
  - 0xFE -> if retry < MAX_RETRY, retry+1 and resend the same byte via INHIBIT; else err code 2.
  - Any other byte -> err code 3.
- Watchdog: counts in RTS, TX and WAIT_RESP. It resets on every fall and on phase entry. Reaching TIMEOUT_CYCLES -> err code 0.
- Any err: release both lines the same cycle, pulse err, return to IDLE. done/err are mutually exclusive and assert on the cycle IDLE is re-entered.
- rx_valid in IDLE/INHIBIT/RTS/TX is ignored by this block, and rx_suppress stays 0 in those states. A cmd_valid held while busy is not accepted.
- The retry count is per byte; it is cleared when moving to byte1.

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE, INHIBIT, RTS, TX, WAIT_RESP)
  - err_code constants
  - PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_CMD_LEDS=8'hED
- One sub-module ps2_tx_frame holds the shifter, parity, bitcnt and line-ACK sample. It is driven by fall and start, and returns frame_done/line_ack. The FSM, timers and retry logic stay in the top.

Test Plan:
- 0xF4, device model clocks at 12.5 kHz and ACKs the line, then rx 0xFA.
  - Data bits 0,0,1,0,1,1,1,1, parity 0, stop released.
  - Clock held low exactly 5000 cycles; done pulse once; err_code unchanged.
- cmd_two: 0xED then 0x07, each answered 0xFA.
  - Parities 1 then 0; two inhibit phases.
  - rx_suppress high during both responses; single done after the second 0xFA.
- 0xFF answered 0xFE, 0xFE, then 0xFA: three transmissions of the identical frame, then done.
  - Answered 0xFE ×3 instead: err with code 2 after the third frame.
- Device never clocks after RTS: err with code 0 exactly TIMEOUT_CYCLES cycles after RTS entry; both lines released; cmd_ready=1 next cycle.
- Data stays high at fall 11 -> err code 1. Separately, response 0x41 -> err code 3.
- Reset asserted at fall 5 of TX: lines released immediately. After release, a new 0xF4 completes normally with correct parity and retry count 0.
